// File: rtl/rx_mass_pkg.sv
// Shared types and constants for the RX mass-receive pattern checker.
package rx_mass_pkg;

  typedef enum logic [1:0] {
    S_LEN  = 2'd0,
    S_DATA = 2'd1,
    S_RPT0 = 2'd2,
    S_RPT1 = 2'd3
  } rx_state_e;

  localparam logic [31:0] ABORT_FLAG = 32'h8000_0000;
  localparam logic [3:0]  KEEP_ALL   = 4'hF;

  // Error counter must stick at all-ones rather than wrap back to zero.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/rx_len_hdr_assemble.sv
// Collects the 4-byte little-endian length header; done pulses on the 4th byte
// with the full length presented combinationally on len.
module rx_len_hdr_assemble (
  input  logic        clk,
  input  logic        rst,
  input  logic        beat,
  input  logic [7:0]  byte_in,
  output logic [1:0]  byte_idx,
  output logic        done,
  output logic [31:0] len
);

  logic [23:0] low_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx <= 2'd0;
      low_q    <= 24'd0;
    end else if (beat) begin
      byte_idx <= byte_idx + 2'd1;
      case (byte_idx)
        2'd0:    low_q[7:0]   <= byte_in;
        2'd1:    low_q[15:8]  <= byte_in;
        2'd2:    low_q[23:16] <= byte_in;
        default: ;
      endcase
    end
  end

  assign done = beat && (byte_idx == 2'd3);
  assign len  = {byte_in, low_q};

endmodule

// File: rtl/rx_specified_len_check.sv
// Receives a length header plus incrementing-pattern payload, then reports
// {received count, error count}. Define RX_SPECIFIED_LEN_TIMEOUT_EN for idle abort.
module rx_specified_len_check
  import rx_mass_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 60000000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        i_tready,
  input  logic        i_tvalid,
  input  logic [7:0]  i_tdata,
  input  logic        o_tready,
  output logic        o_tvalid,
  output logic [31:0] o_tdata,
  output logic [3:0]  o_tkeep,
  output logic        o_tlast,
  output logic        busy,
  output logic        err_sticky
);

  rx_state_e   state, state_nxt;
  logic [31:0] len_q, rx_cnt, rx_cnt_nxt, err_cnt;
  logic        rx_beat, tx_hs, data_beat, pat_err, last_beat;
  logic        hdr_done;
  logic [1:0]  hdr_idx;
  logic [31:0] hdr_len;
  logic        timeout_hit, aborted;

  logic        i_tready_d, o_tvalid_d, o_tlast_d;
  logic [31:0] o_tdata_d;
  logic [3:0]  o_tkeep_d;

  assign rx_beat   = i_tvalid && i_tready;
  assign tx_hs     = o_tvalid && o_tready;
  assign data_beat = rx_beat && (state == S_DATA);
  assign pat_err   = (i_tdata != rx_cnt[7:0]);
  // Compare against len-1 so len=0xFFFFFFFF finishes without the counter wrapping.
  assign last_beat = data_beat && (rx_cnt == len_q - 32'd1);
  assign busy      = !((state == S_LEN) && (hdr_idx == 2'd0));

  rx_len_hdr_assemble u_hdr (
    .clk      (clk),
    .rst      (rst),
    .beat     (rx_beat && (state == S_LEN)),
    .byte_in  (i_tdata),
    .byte_idx (hdr_idx),
    .done     (hdr_done),
    .len      (hdr_len)
  );

`ifdef RX_SPECIFIED_LEN_TIMEOUT_EN
  logic [31:0] idle_cnt;

  assign timeout_hit = (state == S_DATA) && !rx_beat &&
                       (idle_cnt == 32'(TIMEOUT_CYCLES) - 32'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= 32'd0;
      aborted  <= 1'b0;
    end else begin
      idle_cnt <= ((state != S_DATA) || rx_beat) ? 32'd0 : idle_cnt + 32'd1;
      if (hdr_done)
        aborted <= 1'b0;
      else if (timeout_hit)
        aborted <= 1'b1;
    end
  end
`else
  localparam logic [31:0] unused_timeout = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
  assign aborted     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_LEN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LEN:  if (hdr_done) state_nxt = (hdr_len != 32'd0) ? S_DATA : S_RPT0;
      S_DATA: if (last_beat || timeout_hit) state_nxt = S_RPT0;
      S_RPT0: if (tx_hs) state_nxt = S_RPT1;
      S_RPT1: if (tx_hs) state_nxt = S_LEN;
      default: state_nxt = S_LEN;
    endcase
  end

  always_comb begin
    rx_cnt_nxt = rx_cnt;
    if (hdr_done)       rx_cnt_nxt = 32'd0;
    else if (data_beat) rx_cnt_nxt = rx_cnt + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q      <= 32'd0;
      rx_cnt     <= 32'd0;
      err_cnt    <= 32'd0;
      err_sticky <= 1'b0;
    end else begin
      rx_cnt <= rx_cnt_nxt;
      if (hdr_done) begin
        len_q   <= hdr_len;
        err_cnt <= 32'd0;
      end else if (data_beat && pat_err) begin
        err_cnt <= sat_inc32(err_cnt);
      end
      if ((data_beat && pat_err) || timeout_hit)
        err_sticky <= 1'b1;
    end
  end

  // Outputs are decoded from the next state so they are registered yet in step with it.
  always_comb begin
    i_tready_d = 1'b0;
    o_tvalid_d = 1'b0;
    o_tdata_d  = 32'd0;
    o_tkeep_d  = 4'd0;
    o_tlast_d  = 1'b0;
    case (state_nxt)
      S_LEN, S_DATA: i_tready_d = 1'b1;
      S_RPT0: begin
        o_tvalid_d = 1'b1;
        o_tdata_d  = rx_cnt_nxt;
        o_tkeep_d  = KEEP_ALL;
      end
      S_RPT1: begin
        o_tvalid_d = 1'b1;
        o_tdata_d  = err_cnt | (aborted ? ABORT_FLAG : 32'd0);
        o_tkeep_d  = KEEP_ALL;
        o_tlast_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_tready <= 1'b0;
      o_tvalid <= 1'b0;
      o_tdata  <= 32'd0;
      o_tkeep  <= 4'd0;
      o_tlast  <= 1'b0;
    end else begin
      i_tready <= i_tready_d;
      o_tvalid <= o_tvalid_d;
      o_tdata  <= o_tdata_d;
      o_tkeep  <= o_tkeep_d;
      o_tlast  <= o_tlast_d;
    end
  end

endmodule
